// File: rtl/control_sequencer.sv
// Multi-cycle LEGv8 control sequencer: fetches into the instruction register, steps the
// decoder state, and gates control-word side effects while data RAM is not ready.
module control_sequencer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_data,
    output logic [31:0]      ir,
    output logic [1:0]       state,
    input  logic [32:0]      cw_in,
    input  logic             ram_ready,
    output logic [32:0]      cw_out,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       dbg_fsm
);

    // Handshakes: a fetch completes in a cycle where imem_req && imem_ready; a data access
    // completes in a cycle where cw_in[8] && ram_ready. Both sides see the same cycle.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } fsm_t;

    // rf_w, ram_w, pc_fs, status_ld: fields that must not take effect during a stall
    localparam logic [32:0] GATE_MASK = 33'h0_0000_02B4;
    localparam logic [7:0]  LAST_WAIT = 8'(MAX_WAIT - 1);

    fsm_t             r_fsm, w_fsm_nxt;
    logic [31:0]      r_ir;
    logic [1:0]       r_state, w_state_nxt;
    logic [7:0]       r_wait, w_wait_nxt;
    logic             r_fault, w_fault_nxt;
    logic [CNT_W-1:0] r_retired, w_retired_nxt;
    logic             r_first;
    logic             w_ir_load;
    logic             w_stall;
    logic             w_timeout;
    logic             w_req, w_busy;
    logic [32:0]      w_cw;

    assign w_stall   = cw_in[8] && !ram_ready;
    assign w_timeout = (r_wait == LAST_WAIT);

    always_comb begin
        w_fsm_nxt     = r_fsm;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_fault_nxt   = r_fault;
        w_retired_nxt = r_retired;
        w_ir_load     = 1'b0;
        w_req         = 1'b0;
        w_busy        = 1'b0;
        w_cw          = '0;
        case (r_fsm)
            S_FETCH: begin
                // The first cycle out of reset never issues a fetch
                if (run && !r_first) begin
                    w_req  = 1'b1;
                    w_busy = 1'b1;
                    if (imem_ready) begin
                        w_ir_load   = 1'b1;
                        w_wait_nxt  = '0;
                        w_state_nxt = 2'b00;
                        w_fsm_nxt   = S_EXEC;
                    end else if (w_timeout) begin
                        w_fault_nxt = 1'b1;
                        w_fsm_nxt   = S_HALT;
                    end else begin
                        w_wait_nxt = r_wait + 8'd1;
                    end
                end else begin
                    w_wait_nxt = '0;
                end
            end
            S_EXEC: begin
                w_busy = 1'b1;
                if (w_stall) begin
                    w_cw = cw_in & ~GATE_MASK;
                    if (w_timeout) begin
                        w_fault_nxt = 1'b1;
                        w_fsm_nxt   = S_HALT;
                    end else begin
                        w_wait_nxt = r_wait + 8'd1;
                    end
                end else begin
                    w_cw       = cw_in;
                    w_wait_nxt = '0;
                    if (cw_in[1:0] != 2'b00) begin
                        w_state_nxt = cw_in[1:0];
                    end else begin
                        w_state_nxt   = 2'b00;
                        w_retired_nxt = r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
                        w_fsm_nxt     = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                w_busy = 1'b1;
            end
            default: begin
                w_fsm_nxt = S_FETCH;
            end
        endcase
        if (!reset_n) begin
            w_req  = 1'b0;
            w_busy = 1'b0;
            w_cw   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_fsm     <= S_FETCH;
            r_ir      <= '0;
            r_state   <= 2'b00;
            r_wait    <= '0;
            r_fault   <= 1'b0;
            r_retired <= '0;
            r_first   <= 1'b1;
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_fault   <= w_fault_nxt;
            r_retired <= w_retired_nxt;
            r_first   <= 1'b0;
            if (w_ir_load) begin
                r_ir <= imem_data;
            end
        end
    end

    assign imem_req = w_req;
    assign busy     = w_busy;
    assign cw_out   = w_cw;
    assign ir       = r_ir;
    assign state    = r_state;
    assign fault    = r_fault;
    assign retired  = r_retired;
    assign dbg_fsm  = r_fsm;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed cycle table, hand-written corner sequences, and
// randomized instructions checked against a transaction-level expectation builder.
module tb_control_sequencer;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 2;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [32:0] IDLE = '0;

    logic             clock;
    logic             reset_n;
    logic             run;
    logic             imem_req;
    logic             imem_ready;
    logic [31:0]      imem_data;
    logic [31:0]      ir;
    logic [1:0]       state;
    logic [32:0]      cw_in;
    logic             ram_ready;
    logic [32:0]      cw_out;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] retired;
    logic [1:0]       dbg_fsm;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        rst_n;
        logic        run;
        logic        imr;
        logic [31:0] data;
        logic [32:0] cw;
        logic        rr;
        logic        e_req;
        logic        e_busy;
        logic [32:0] e_cw;
        logic        st_chk;
        logic [1:0]  e_state;
        logic        e_fault;
        logic        ir_chk;
        logic [31:0] e_ir;
        logic        ret_chk;
        logic [1:0]  e_ret;
        logic        fsm_chk;
        logic [1:0]  e_fsm;
    } vec_t;

    control_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_data  (imem_data),
        .ir         (ir),
        .state      (state),
        .cw_in      (cw_in),
        .ram_ready  (ram_ready),
        .cw_out     (cw_out),
        .busy       (busy),
        .fault      (fault),
        .retired    (retired),
        .dbg_fsm    (dbg_fsm)
    );

    // clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [32:0] rnd33();
        return {rb(), 32'($urandom())};
    endfunction

    function automatic logic [32:0] mk(input logic [32:0] base, input logic ram_en,
                                       input logic [1:0] nxt);
        logic [32:0] c;
        c      = base;
        c[8]   = ram_en;
        c[1:0] = nxt;
        return c;
    endfunction

    // stall word: rf_w, ram_w, status_ld cleared, pc_fs forced to hold
    function automatic logic [32:0] gate(input logic [32:0] cw);
        logic [32:0] c;
        c      = cw;
        c[9]   = 1'b0;
        c[7]   = 1'b0;
        c[5:4] = 2'b00;
        c[2]   = 1'b0;
        return c;
    endfunction

    function automatic vec_t mkv(input logic rst, input logic r, input logic imr,
                                 input logic [31:0] data, input logic [32:0] cw, input logic rr,
                                 input logic e_req, input logic e_busy, input logic [32:0] e_cw,
                                 input logic [1:0] e_state, input logic e_fault,
                                 input logic ir_chk, input logic [31:0] e_ir,
                                 input logic ret_chk, input logic [1:0] e_ret);
        vec_t v;
        v.rst_n = rst;   v.run = r;       v.imr = imr;       v.data = data;
        v.cw = cw;       v.rr = rr;       v.e_req = e_req;   v.e_busy = e_busy;
        v.e_cw = e_cw;   v.st_chk = Y;    v.e_state = e_state; v.e_fault = e_fault;
        v.ir_chk = ir_chk; v.e_ir = e_ir; v.ret_chk = ret_chk; v.e_ret = e_ret;
        v.fsm_chk = N;   v.e_fsm = 2'd0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: called at posedge+1, samples at negedge, returns at next posedge+1
    task automatic apply(input vec_t v);
        reset_n    = v.rst_n;
        run        = v.run;
        imem_ready = v.imr;
        imem_data  = v.data;
        cw_in      = v.cw;
        ram_ready  = v.rr;
        @(negedge clock);
        chk("imem_req", 64'(imem_req), 64'(v.e_req));
        chk("busy", 64'(busy), 64'(v.e_busy));
        chk("cw_out", 64'(cw_out), 64'(v.e_cw));
        chk("rf_w", 64'(cw_out[9]), 64'(v.e_cw[9]));
        if (v.st_chk) begin
            chk("state", 64'(state), 64'(v.e_state));
            chk("fault", 64'(fault), 64'(v.e_fault));
        end
        if (v.ir_chk)  chk("ir", 64'(ir), 64'(v.e_ir));
        if (v.ret_chk) chk("retired", 64'(retired), 64'(v.e_ret));
        if (v.fsm_chk) chk("dbg_fsm", 64'(dbg_fsm), 64'(v.e_fsm));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        vec_t v;
        v = mkv(N, Y, Y, 32'($urandom()), rnd33(), Y, N, N, IDLE, 2'd0, N, N, 32'd0, N, 2'd0);
        v.st_chk = N;
        apply(v);
        v = mkv(N, Y, Y, 32'($urandom()), rnd33(), Y, N, N, IDLE, 2'd0, N, Y, 32'd0, Y, 2'd0);
        apply(v);
    endtask

    // first cycle out of reset: run=1 and imem_ready=1 must still not fetch
    task automatic blocked_cycle();
        vec_t v;
        v = mkv(Y, Y, Y, 32'hDEAD_BEEF, IDLE, N, N, N, IDLE, 2'd0, N, Y, 32'd0, Y, 2'd0);
        v.fsm_chk = Y;
        v.e_fsm   = 2'd0;
        apply(v);
    endtask

    vec_t        tbl[17];
    logic [32:0] cw_a, cw_l, cw_m1, cw_m2, cw_t;
    logic [31:0] d1, d2, d3, d4, cur_ir;
    int          ret;

    initial begin
        reset_n = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_data = '0;
        cw_in = '0; ram_ready = 1'b0;
        @(posedge clock);
        #1;

        cw_a  = mk(33'h1_2345_6789, N, 2'b00);
        cw_l  = mk(33'h0_ABCD_E2F4, Y, 2'b00);
        cw_m1 = mk(33'h0_5555_1234, N, 2'b01);
        cw_m2 = mk(33'h1_0F0F_0F0F, N, 2'b00);
        d1 = 32'h9100_0421; d2 = 32'hF840_0020; d3 = 32'h8B02_0020; d4 = 32'hD280_0001;

        //              rst run imr data cw     rr  req busy e_cw          st     flt irc ir  rc  ret
        tbl[0]  = mkv(Y, Y, Y, d1, cw_a,  N, N, N, IDLE,        2'd0, N, Y, 32'd0, Y, 2'd0);
        tbl[1]  = mkv(Y, Y, Y, d1, cw_a,  N, Y, Y, IDLE,        2'd0, N, Y, 32'd0, Y, 2'd0);
        tbl[2]  = mkv(Y, Y, N, 32'd0, cw_a, N, N, Y, cw_a,      2'd0, N, Y, d1,    Y, 2'd0);
        tbl[3]  = mkv(Y, N, Y, 32'd0, cw_a, N, N, N, IDLE,      2'd0, N, Y, d1,    Y, 2'd1);
        tbl[4]  = mkv(Y, Y, N, 32'd0, cw_l, N, Y, Y, IDLE,      2'd0, N, Y, d1,    Y, 2'd1);
        tbl[5]  = mkv(Y, Y, Y, d2, cw_l,  N, Y, Y, IDLE,        2'd0, N, Y, d1,    Y, 2'd1);
        tbl[6]  = mkv(Y, Y, N, 32'd0, cw_l, N, N, Y, gate(cw_l), 2'd0, N, Y, d2,   Y, 2'd1);
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
        tbl[9]  = mkv(Y, Y, N, 32'd0, cw_l, Y, N, Y, cw_l,      2'd0, N, Y, d2,    Y, 2'd1);
        tbl[10] = mkv(Y, N, Y, d3, cw_a,  N, N, N, IDLE,        2'd0, N, Y, d2,    Y, 2'd2);
        tbl[11] = mkv(Y, Y, Y, d3, cw_m1, N, Y, Y, IDLE,        2'd0, N, Y, d2,    Y, 2'd2);
        tbl[12] = mkv(Y, Y, N, 32'd0, cw_m1, N, N, Y, cw_m1,    2'd0, N, Y, d3,    Y, 2'd2);
        tbl[13] = mkv(Y, Y, N, 32'd0, cw_m2, N, N, Y, cw_m2,    2'd1, N, Y, d3,    Y, 2'd2);
        tbl[14] = mkv(Y, N, N, 32'd0, cw_a, Y, N, N, IDLE,      2'd0, N, Y, d3,    Y, 2'd3);
        tbl[15] = mkv(Y, N, Y, 32'h1234_5678, cw_a, Y, N, N, IDLE, 2'd0, N, Y, d3, Y, 2'd3);
        tbl[16] = tbl[15];

        do_reset();
        for (int i = 0; i < 17; i++) apply(tbl[i]);

        // data RAM timeout: MAX_WAIT stalls then HALT, inputs ignored until reset
        cw_t = mk(33'h0_0000_0FFC, Y, 2'b00);
        apply(mkv(Y, Y, Y, d4, cw_t, N, Y, Y, IDLE, 2'd0, N, Y, d3, Y, 2'd3));
        for (int i = 0; i < MAX_WAIT; i++)
            apply(mkv(Y, Y, N, 32'd0, cw_t, N, N, Y, gate(cw_t), 2'd0, N, Y, d4, Y, 2'd3));
        for (int i = 0; i < 5; i++)
            apply(mkv(Y, rb(), rb(), 32'($urandom()), cw_t, rb(), N, Y, IDLE, 2'd0, Y, Y, d4,
                      Y, 2'd3));
        do_reset();
        blocked_cycle();

        // fetch timeout
        for (int i = 0; i < MAX_WAIT; i++)
            apply(mkv(Y, Y, N, 32'd0, IDLE, N, Y, Y, IDLE, 2'd0, N, Y, 32'd0, Y, 2'd0));
        apply(mkv(Y, Y, Y, d1, IDLE, Y, N, Y, IDLE, 2'd0, Y, Y, 32'd0, Y, 2'd0));
        do_reset();
        blocked_cycle();

        // ready on exactly the MAX_WAIT-th waiting cycle commits
        apply(mkv(Y, Y, Y, d2, cw_l, N, Y, Y, IDLE, 2'd0, N, Y, 32'd0, Y, 2'd0));
        for (int i = 0; i < MAX_WAIT - 1; i++)
            apply(mkv(Y, Y, N, 32'd0, cw_l, N, N, Y, gate(cw_l), 2'd0, N, Y, d2, Y, 2'd0));
        apply(mkv(Y, Y, N, 32'd0, cw_l, Y, N, Y, cw_l, 2'd0, N, Y, d2, Y, 2'd0));
        apply(mkv(Y, N, N, 32'd0, IDLE, N, N, N, IDLE, 2'd0, N, Y, d2, Y, 2'd1));

        // counter wrap with CNT_W=2
        do_reset();
        blocked_cycle();
        for (int i = 0; i < 5; i++) begin
            apply(mkv(Y, Y, Y, d1 + 32'(i), cw_a, N, Y, Y, IDLE, 2'd0, N, N, 32'd0, Y, 2'(i)));
            apply(mkv(Y, Y, N, 32'd0, cw_a, N, N, Y, cw_a, 2'd0, N, Y, d1 + 32'(i), Y, 2'(i)));
        end
        apply(mkv(Y, N, N, 32'd0, IDLE, N, N, N, IDLE, 2'd0, N, Y, d1 + 32'd4, Y, 2'd1));

        // reset during an EXEC stall abandons the instruction with no rf_w pulse
        apply(mkv(Y, Y, Y, d3, cw_l, N, Y, Y, IDLE, 2'd0, N, N, 32'd0, Y, 2'd1));
        apply(mkv(Y, Y, N, 32'd0, cw_l, N, N, Y, gate(cw_l), 2'd0, N, Y, d3, Y, 2'd1));
        begin
            vec_t v;
            v = mkv(N, Y, N, 32'd0, cw_l, N, N, N, IDLE, 2'd0, N, Y, d3, Y, 2'd1);
            v.st_chk = N;
            apply(v);
        end
        blocked_cycle();

        // randomized instructions against the transaction-level expectation builder
        do_reset();
        blocked_cycle();
        cur_ir = 32'd0;
        ret    = 0;
        for (int k = 0; k < 60; k++) begin
            int          idle, fw, nsteps, w;
            logic [1:0]  st, nxt;
            logic        en;
            logic [32:0] cw;
            logic [31:0] data;
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++)
                apply(mkv(Y, N, rb(), 32'($urandom()), rnd33(), rb(), N, N, IDLE, 2'd0, N,
                          Y, cur_ir, Y, 2'(ret)));
            fw = $urandom_range(0, MAX_WAIT - 1);
            for (int i = 0; i < fw; i++)
                apply(mkv(Y, Y, N, 32'($urandom()), rnd33(), rb(), Y, Y, IDLE, 2'd0, N,
                          Y, cur_ir, Y, 2'(ret)));
            data = 32'($urandom());
            apply(mkv(Y, Y, Y, data, rnd33(), rb(), Y, Y, IDLE, 2'd0, N, Y, cur_ir,
                      Y, 2'(ret)));
            cur_ir = data;
            nsteps = $urandom_range(1, 3);
            st     = 2'd0;
            for (int s = 0; s < nsteps; s++) begin
                nxt = (s == nsteps - 1) ? 2'd0 : 2'($urandom_range(1, 3));
                en  = rb();
                cw  = mk(rnd33(), en, nxt);
                if (en) begin
                    w = $urandom_range(0, MAX_WAIT - 1);
                    for (int i = 0; i < w; i++)
                        apply(mkv(Y, rb(), rb(), 32'($urandom()), cw, N, N, Y, gate(cw), st,
                                  N, Y, cur_ir, Y, 2'(ret)));
                end
                apply(mkv(Y, rb(), rb(), 32'($urandom()), cw, en ? Y : rb(), N, Y, cw, st, N,
                          Y, cur_ir, Y, 2'(ret)));
                st = nxt;
            end
            ret = (ret + 1) % (1 << CNT_W);
        end
        apply(mkv(Y, N, N, 32'd0, IDLE, N, N, N, IDLE, 2'd0, N, Y, cur_ir, Y, 2'(ret)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
